cg_tlb_setassociative: RTL and testbench

Parametrised set-associative TLB, the successor to the team's fully-associative TLB. It serves the core's translation port and owns a valid/ready miss handshake to the PTW. It adds an explicit lookup stall, page-fault reporting, ASID/vaddr-selective flush (SFENCE.VMA) and per-set bit-PLRU replacement. It sits between the core's load/store/fetch address stage and the shared PTW.

---
 rtl/cg_tlb_setassociative.sv | 273 +++++++++++++++++++++++++++
 tb/tb_cg_tlb_setassociative.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cg_tlb_setassociative.sv
// cg_tlb_setassociative: set-associative TLB with PTW miss handshake, lookup
// stall, page-fault strobe, ASID/vaddr-selective flush and per-set bit-PLRU.
// Optional feature: define CG_TLB_GLOBAL_EN to store a G bit per entry
// (i_ptw_pte_attr[5]); global entries match any ASID and survive ASID flushes.
module cg_tlb_setassociative #(
  parameter int VADDR_WIDTH  = 39,
  parameter int PADDR_WIDTH  = 56,
  parameter int PPN_WIDTH    = 44,
  parameter int OFFSET_WIDTH = 12,
  parameter int ASID_WIDTH   = 16,
  parameter int ATTR_WIDTH   = 11,
  parameter int SET_NUM      = 8,
  parameter int WAY_NUM      = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_vaddr_valid,
  output logic                    o_ready,
  input  logic [VADDR_WIDTH-1:0]  i_vaddr,
  input  logic [ASID_WIDTH-1:0]   i_asid,
  output logic                    o_paddr_valid,
  output logic [PADDR_WIDTH-1:0]  o_paddr,
  output logic [ATTR_WIDTH-1:0]   o_pte_attr,
  output logic                    o_fault,
  output logic                    o_miss_valid,
  input  logic                    i_miss_ready,
  output logic [VADDR_WIDTH-1:0]  o_miss_vaddr,
  output logic [ASID_WIDTH-1:0]   o_miss_asid,
  input  logic                    i_ptw_valid,
  input  logic                    i_ptw_fault,
  input  logic [PADDR_WIDTH-1:0]  i_ptw_paddr,
  input  logic [ATTR_WIDTH-1:0]   i_ptw_pte_attr,
  input  logic                    i_flush_valid,
  output logic                    o_flush_ready,
  input  logic                    i_flush_asid_en,
  input  logic [ASID_WIDTH-1:0]   i_flush_asid,
  input  logic                    i_flush_vaddr_en,
  input  logic [VADDR_WIDTH-1:0]  i_flush_vaddr
);

  localparam int IDX_W = $clog2(SET_NUM);
  localparam int TAG_W = VADDR_WIDTH - OFFSET_WIDTH - IDX_W;
  localparam int WAY_W = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;

  typedef enum logic [1:0] {IDLE, MISS_REQ, WAIT_PTW, FLUSH} state_t;

  state_t state, state_nxt;

  // Entry storage: valid/MRU are control, the rest is data
  logic [WAY_NUM-1:0]    valid_arr [SET_NUM];
  logic [WAY_NUM-1:0]    mru_arr   [SET_NUM];
  logic [TAG_W-1:0]      tag_arr   [SET_NUM][WAY_NUM];
  logic [ASID_WIDTH-1:0] asid_arr  [SET_NUM][WAY_NUM];
  logic [PPN_WIDTH-1:0]  ppn_arr   [SET_NUM][WAY_NUM];
  logic [ATTR_WIDTH-1:0] attr_arr  [SET_NUM][WAY_NUM];
`ifdef CG_TLB_GLOBAL_EN
  logic [WAY_NUM-1:0]    g_arr     [SET_NUM];
`endif

  // Flush operands
  logic                  fl_asid_en_q;
  logic [ASID_WIDTH-1:0] fl_asid_q;
  logic                  fl_vaddr_en_q;
  logic [TAG_W-1:0]      fl_tag_q;
  logic [IDX_W-1:0]      fl_idx_q;
  logic                  fl_last;
  logic [WAY_NUM-1:0]    fl_kill;

  // Result stage
  logic                   res_vld_p1;
  logic                   fault_p1;
  logic [PADDR_WIDTH-1:0] paddr_p1;
  logic [ATTR_WIDTH-1:0]  attr_p1;
  logic [VADDR_WIDTH-1:0] miss_vaddr_q;
  logic [ASID_WIDTH-1:0]  miss_asid_q;

  logic [IDX_W-1:0]     lk_idx;
  logic [TAG_W-1:0]     lk_tag;
  logic [IDX_W-1:0]     ms_idx;
  logic [TAG_W-1:0]     ms_tag;
  logic [PPN_WIDTH-1:0] ptw_ppn;
  logic                 lk_acc;
  logic                 fl_acc;
  logic                 ptw_done;
  logic                 fill_en;
  logic [WAY_NUM-1:0]   hit_vec;
  logic                 hit;
  logic [WAY_W-1:0]     hit_way;
  logic [WAY_W-1:0]     vic_way;
  logic                 vic_found;
  logic                 unused_bits;

  assign lk_idx   = i_vaddr[OFFSET_WIDTH +: IDX_W];
  assign lk_tag   = i_vaddr[VADDR_WIDTH-1 -: TAG_W];
  assign ms_idx   = miss_vaddr_q[OFFSET_WIDTH +: IDX_W];
  assign ms_tag   = miss_vaddr_q[VADDR_WIDTH-1 -: TAG_W];
  assign ptw_ppn  = i_ptw_paddr[PADDR_WIDTH-1 -: PPN_WIDTH];
  assign lk_acc   = i_vaddr_valid & o_ready;
  assign fl_acc   = i_flush_valid & o_flush_ready;
  assign ptw_done = (state == WAIT_PTW) & i_ptw_valid;
  assign fill_en  = ptw_done & ~i_ptw_fault;
  assign fl_last  = fl_vaddr_en_q | (fl_idx_q == IDX_W'(SET_NUM - 1));

  assign unused_bits = &{1'b0, i_flush_vaddr[OFFSET_WIDTH-1:0],
                         i_ptw_paddr[PADDR_WIDTH-PPN_WIDTH-1:0]};

  // Set the touched way's MRU bit; on saturation keep only the touched way
  function automatic logic [WAY_NUM-1:0] mru_touch(input logic [WAY_NUM-1:0] cur,
                                                   input logic [WAY_W-1:0]   way);
    logic [WAY_NUM-1:0] onehot;
    logic [WAY_NUM-1:0] nxt;
    onehot      = '0;
    onehot[way] = 1'b1;
    nxt         = cur | onehot;
    if (&nxt) nxt = onehot;
    return nxt;
  endfunction

  // Tag/ASID compare across the indexed set, lowest matching way wins
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAY_NUM; w++) begin
`ifdef CG_TLB_GLOBAL_EN
      hit_vec[w] = valid_arr[lk_idx][w] & (tag_arr[lk_idx][w] == lk_tag) &
                   ((asid_arr[lk_idx][w] == i_asid) | g_arr[lk_idx][w]);
`else
      hit_vec[w] = valid_arr[lk_idx][w] & (tag_arr[lk_idx][w] == lk_tag) &
                   (asid_arr[lk_idx][w] == i_asid);
`endif
    end
    for (int w = 0; w < WAY_NUM; w++) begin
      if (hit_vec[w] && !hit) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim: lowest invalid way, else lowest way whose MRU bit is clear
  always_comb begin
    vic_way   = '0;
    vic_found = 1'b0;
    for (int w = 0; w < WAY_NUM; w++) begin
      if (!valid_arr[ms_idx][w] && !vic_found) begin
        vic_way   = WAY_W'(w);
        vic_found = 1'b1;
      end
    end
    for (int w = 0; w < WAY_NUM; w++) begin
      if (!mru_arr[ms_idx][w] && !vic_found) begin
        vic_way   = WAY_W'(w);
        vic_found = 1'b1;
      end
    end
  end

  // Flush match per way in the set currently being swept
  always_comb begin
    for (int w = 0; w < WAY_NUM; w++) begin
`ifdef CG_TLB_GLOBAL_EN
      fl_kill[w] = (fl_asid_en_q ? ((asid_arr[fl_idx_q][w] == fl_asid_q) & ~g_arr[fl_idx_q][w]) : 1'b1) &
                   (fl_vaddr_en_q ? (tag_arr[fl_idx_q][w] == fl_tag_q) : 1'b1);
`else
      fl_kill[w] = (fl_asid_en_q ? (asid_arr[fl_idx_q][w] == fl_asid_q) : 1'b1) &
                   (fl_vaddr_en_q ? (tag_arr[fl_idx_q][w] == fl_tag_q) : 1'b1);
`endif
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; flush takes priority over a same-cycle lookup
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (fl_acc) state_nxt = FLUSH;
                else if (lk_acc && !hit) state_nxt = MISS_REQ;
      MISS_REQ: if (i_miss_ready) state_nxt = WAIT_PTW;
      WAIT_PTW: if (i_ptw_valid) state_nxt = IDLE;
      FLUSH:    if (fl_last) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // State-decoded handshake outputs
  always_comb begin
    o_miss_valid  = (state == MISS_REQ);
    o_flush_ready = (state == IDLE);
    o_ready       = (state == IDLE) & ~i_flush_valid;
  end

  // ---- p1: translation result, fault strobe and latched miss request ----
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      res_vld_p1   <= 1'b0;
      fault_p1     <= 1'b0;
      paddr_p1     <= '0;
      attr_p1      <= '0;
      miss_vaddr_q <= '0;
      miss_asid_q  <= '0;
    end else begin
      res_vld_p1 <= (lk_acc & hit) | fill_en;
      fault_p1   <= ptw_done & i_ptw_fault;
      if (lk_acc && hit) begin
        paddr_p1 <= {ppn_arr[lk_idx][hit_way], i_vaddr[OFFSET_WIDTH-1:0]};
        attr_p1  <= attr_arr[lk_idx][hit_way];
      end else if (fill_en) begin
        paddr_p1 <= {ptw_ppn, miss_vaddr_q[OFFSET_WIDTH-1:0]};
        attr_p1  <= i_ptw_pte_attr;
      end
      if (lk_acc && !hit) begin
        miss_vaddr_q <= i_vaddr;
        miss_asid_q  <= i_asid;
      end
    end
  end

  assign o_paddr_valid = res_vld_p1;
  assign o_fault       = fault_p1;
  assign o_paddr       = paddr_p1;
  assign o_pte_attr    = attr_p1;
  assign o_miss_vaddr  = miss_vaddr_q;
  assign o_miss_asid   = miss_asid_q;

  // Valid and MRU bits: hit touch, fill install, flush invalidate
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int s = 0; s < SET_NUM; s++) begin
        valid_arr[s] <= '0;
        mru_arr[s]   <= '0;
      end
    end else begin
      if (lk_acc && hit) mru_arr[lk_idx] <= mru_touch(mru_arr[lk_idx], hit_way);
      if (fill_en) begin
        valid_arr[ms_idx][vic_way] <= 1'b1;
        mru_arr[ms_idx]            <= mru_touch(mru_arr[ms_idx], vic_way);
      end
      if (state == FLUSH) valid_arr[fl_idx_q] <= valid_arr[fl_idx_q] & ~fl_kill;
    end
  end

  // Entry payload written on a successful PTW fill
  always_ff @(posedge i_clk) begin
    if (fill_en) begin
      tag_arr[ms_idx][vic_way]  <= ms_tag;
      asid_arr[ms_idx][vic_way] <= miss_asid_q;
      ppn_arr[ms_idx][vic_way]  <= ptw_ppn;
      attr_arr[ms_idx][vic_way] <= i_ptw_pte_attr;
`ifdef CG_TLB_GLOBAL_EN
      g_arr[ms_idx][vic_way]    <= i_ptw_pte_attr[5];
`endif
    end
  end

  // Flush operand latch and set sweep counter
  always_ff @(posedge i_clk) begin
    if (fl_acc) begin
      fl_asid_en_q  <= i_flush_asid_en;
      fl_asid_q     <= i_flush_asid;
      fl_vaddr_en_q <= i_flush_vaddr_en;
      fl_tag_q      <= i_flush_vaddr[VADDR_WIDTH-1 -: TAG_W];
      fl_idx_q      <= i_flush_vaddr_en ? i_flush_vaddr[OFFSET_WIDTH +: IDX_W] : '0;
    end else if (state == FLUSH && !fl_last) begin
      fl_idx_q <= fl_idx_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_cg_tlb_setassociative.sv
// Directed testbench for cg_tlb_setassociative (default parameters).
module tb_cg_tlb_setassociative;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_vaddr_valid = 1'b0;
  logic        o_ready;
  logic [38:0] i_vaddr = '0;
  logic [15:0] i_asid = '0;
  logic        o_paddr_valid;
  logic [55:0] o_paddr;
  logic [10:0] o_pte_attr;
  logic        o_fault;
  logic        o_miss_valid;
  logic        i_miss_ready = 1'b0;
  logic [38:0] o_miss_vaddr;
  logic [15:0] o_miss_asid;
  logic        i_ptw_valid = 1'b0;
  logic        i_ptw_fault = 1'b0;
  logic [55:0] i_ptw_paddr = '0;
  logic [10:0] i_ptw_pte_attr = '0;
  logic        i_flush_valid = 1'b0;
  logic        o_flush_ready;
  logic        i_flush_asid_en = 1'b0;
  logic [15:0] i_flush_asid = '0;
  logic        i_flush_vaddr_en = 1'b0;
  logic [38:0] i_flush_vaddr = '0;

  int vectors = 0;
  int miscompares = 0;

  cg_tlb_setassociative dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_vaddr_valid(i_vaddr_valid), .o_ready(o_ready),
    .i_vaddr(i_vaddr), .i_asid(i_asid),
    .o_paddr_valid(o_paddr_valid), .o_paddr(o_paddr), .o_pte_attr(o_pte_attr),
    .o_fault(o_fault),
    .o_miss_valid(o_miss_valid), .i_miss_ready(i_miss_ready),
    .o_miss_vaddr(o_miss_vaddr), .o_miss_asid(o_miss_asid),
    .i_ptw_valid(i_ptw_valid), .i_ptw_fault(i_ptw_fault),
    .i_ptw_paddr(i_ptw_paddr), .i_ptw_pte_attr(i_ptw_pte_attr),
    .i_flush_valid(i_flush_valid), .o_flush_ready(o_flush_ready),
    .i_flush_asid_en(i_flush_asid_en), .i_flush_asid(i_flush_asid),
    .i_flush_vaddr_en(i_flush_vaddr_en), .i_flush_vaddr(i_flush_vaddr)
  );

  always #5 i_clk = ~i_clk;

  // One accepted lookup; returns #1 after the accepting edge
  task automatic lookup(input logic [38:0] va, input logic [15:0] as);
    i_vaddr_valid = 1'b1;
    i_vaddr       = va;
    i_asid        = as;
    @(posedge i_clk); #1;
    i_vaddr_valid = 1'b0;
  endtask

  // Accept the pending miss request, then answer it one cycle later
  task automatic respond(input logic [55:0] pa, input logic [10:0] attr, input logic flt);
    i_miss_ready = 1'b1;
    @(posedge i_clk); #1;
    i_miss_ready   = 1'b0;
    i_ptw_valid    = 1'b1;
    i_ptw_paddr    = pa;
    i_ptw_pte_attr = attr;
    i_ptw_fault    = flt;
    @(posedge i_clk); #1;
    i_ptw_valid = 1'b0;
    i_ptw_fault = 1'b0;
  endtask

  task automatic fill(input logic [38:0] va, input logic [15:0] as,
                      input logic [55:0] pa, input logic [10:0] attr);
    lookup(va, as);
    respond(pa, attr, 1'b0);
  endtask

  // Issue a flush and count cycles until o_flush_ready returns (bounded)
  task automatic do_flush(input logic aen, input logic [15:0] as, input logic ven,
                          input logic [38:0] va, output int busy);
    i_flush_valid    = 1'b1;
    i_flush_asid_en  = aen;
    i_flush_asid     = as;
    i_flush_vaddr_en = ven;
    i_flush_vaddr    = va;
    @(posedge i_clk); #1;
    i_flush_valid = 1'b0;
    busy = 0;
    while (o_flush_ready !== 1'b1 && busy < 64) begin
      busy++;
      @(posedge i_clk); #1;
    end
  endtask

  task automatic test_reset();
    vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b want 1", o_ready); end
    vectors++; if (o_flush_ready !== 1'b1) begin miscompares++; $display("FAIL rst_flush_ready got %b want 1", o_flush_ready); end
    vectors++; if (o_paddr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_paddr_valid got %b want 0", o_paddr_valid); end
    vectors++; if (o_fault !== 1'b0) begin miscompares++; $display("FAIL rst_fault got %b want 0", o_fault); end
    vectors++; if (o_miss_valid !== 1'b0) begin miscompares++; $display("FAIL rst_miss_valid got %b want 0", o_miss_valid); end
    vectors++; if (o_paddr !== 56'h0) begin miscompares++; $display("FAIL rst_paddr got %h want 0", o_paddr); end
    vectors++; if (o_miss_vaddr !== 39'h0) begin miscompares++; $display("FAIL rst_miss_vaddr got %h want 0", o_miss_vaddr); end
  endtask

  task automatic test_miss_fill();
    lookup(39'h12345678, 16'd1);
    vectors++; if (o_miss_valid !== 1'b1) begin miscompares++; $display("FAIL miss_valid got %b want 1", o_miss_valid); end
    vectors++; if (o_miss_vaddr !== 39'h12345678) begin miscompares++; $display("FAIL miss_vaddr got %h want 12345678", o_miss_vaddr); end
    vectors++; if (o_miss_asid !== 16'd1) begin miscompares++; $display("FAIL miss_asid got %h want 1", o_miss_asid); end
    vectors++; if (o_paddr_valid !== 1'b0) begin miscompares++; $display("FAIL miss_no_result got %b want 0", o_paddr_valid); end
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk); #1;
      vectors++; if (o_miss_valid !== 1'b1 || o_miss_vaddr !== 39'h12345678) begin
        miscompares++; $display("FAIL miss_hold%0d got %b/%h want 1/12345678", i, o_miss_valid, o_miss_vaddr); end
    end
    respond(56'hABCDE000, 11'h0CF, 1'b0);
    vectors++; if (o_paddr_valid !== 1'b1) begin miscompares++; $display("FAIL fill_valid got %b want 1", o_paddr_valid); end
    vectors++; if (o_paddr !== 56'hABCDE678) begin miscompares++; $display("FAIL fill_paddr got %h want abcde678", o_paddr); end
    vectors++; if (o_pte_attr !== 11'h0CF) begin miscompares++; $display("FAIL fill_attr got %h want 0cf", o_pte_attr); end
    vectors++; if (o_fault !== 1'b0) begin miscompares++; $display("FAIL fill_fault got %b want 0", o_fault); end
    @(posedge i_clk); #1;
    vectors++; if (o_paddr_valid !== 1'b0) begin miscompares++; $display("FAIL fill_pulse got %b want 0", o_paddr_valid); end
    // Stray PTW response while idle must be ignored
    i_ptw_valid = 1'b1; i_ptw_paddr = 56'hDEAD000;
    @(posedge i_clk); #1;
    i_ptw_valid = 1'b0;
    vectors++; if (o_paddr_valid !== 1'b0 || o_ready !== 1'b1) begin
      miscompares++; $display("FAIL stray_ptw got %b/%b want 0/1", o_paddr_valid, o_ready); end
    lookup(39'h12345678, 16'd1);
    vectors++; if (o_paddr_valid !== 1'b1 || o_miss_valid !== 1'b0) begin
      miscompares++; $display("FAIL relookup_hit got %b/%b want 1/0", o_paddr_valid, o_miss_valid); end
    vectors++; if (o_paddr !== 56'hABCDE678) begin miscompares++; $display("FAIL relookup_paddr got %h want abcde678", o_paddr); end
  endtask

  task automatic test_replacement();
    // Set 0: ways 0..3 <- tags 0..3; MRU after fills = 1000
    for (int i = 0; i < 4; i++) fill(39'(i * 32'h8000), 16'd1, 56'(32'h100000 * (i + 1)), 11'h001);
    // Hits on ways 0,1,2 -> 1001, 1011, then saturate to 0100
    for (int i = 0; i < 3; i++) begin
      lookup(39'(i * 32'h8000), 16'd1);
      vectors++; if (o_paddr_valid !== 1'b1 || o_paddr !== 56'(32'h100000 * (i + 1))) begin
        miscompares++; $display("FAIL repl_hit%0d got %b/%h want 1/%h", i, o_paddr_valid, o_paddr, 32'h100000 * (i + 1)); end
    end
    // Full set, lowest clear MRU bit is way 0 -> 0x0 evicted
    lookup(39'h20000, 16'd1);
    vectors++; if (o_miss_valid !== 1'b1) begin miscompares++; $display("FAIL repl_miss got %b want 1", o_miss_valid); end
    respond(56'h500000, 11'h002, 1'b0);
    vectors++; if (o_paddr_valid !== 1'b1 || o_paddr !== 56'h500000) begin
      miscompares++; $display("FAIL repl_fill got %b/%h want 1/500000", o_paddr_valid, o_paddr); end
    lookup(39'h18000, 16'd1);
    vectors++; if (o_paddr_valid !== 1'b1 || o_paddr !== 56'h400000) begin
      miscompares++; $display("FAIL repl_keep3 got %b/%h want 1/400000", o_paddr_valid, o_paddr); end
    lookup(39'h20000, 16'd1);
    vectors++; if (o_paddr_valid !== 1'b1 || o_paddr !== 56'h500000) begin
      miscompares++; $display("FAIL repl_new got %b/%h want 1/500000", o_paddr_valid, o_paddr); end
    lookup(39'h0, 16'd1);
    vectors++; if (o_miss_valid !== 1'b1 || o_paddr_valid !== 1'b0) begin
      miscompares++; $display("FAIL repl_evicted got %b/%b want 1/0", o_miss_valid, o_paddr_valid); end
    respond(56'h0, 11'h0, 1'b1);
  endtask

  task automatic test_flush_vaddr();
    int busy;
    do_flush(1'b0, 16'd0, 1'b1, 39'h18000, busy);
    vectors++; if (busy != 1) begin miscompares++; $display("FAIL fv_busy got %0d want 1", busy); end
    lookup(39'h18000, 16'd1);
    vectors++; if (o_miss_valid !== 1'b1) begin miscompares++; $display("FAIL fv_gone got %b want 1", o_miss_valid); end
    respond(56'h0, 11'h0, 1'b1);
    lookup(39'h8000, 16'd1);
    vectors++; if (o_paddr_valid !== 1'b1 || o_paddr !== 56'h200000) begin
      miscompares++; $display("FAIL fv_other got %b/%h want 1/200000", o_paddr_valid, o_paddr); end
  endtask

  task automatic test_asid();
    lookup(39'h12345678, 16'd2);
    vectors++; if (o_miss_valid !== 1'b1 || o_miss_asid !== 16'd2) begin
      miscompares++; $display("FAIL asid_miss got %b/%h want 1/2", o_miss_valid, o_miss_asid); end
    respond(56'h77777000, 11'h020, 1'b0);
    vectors++; if (o_paddr !== 56'h77777678) begin miscompares++; $display("FAIL asid_fill got %h want 77777678", o_paddr); end
    lookup(39'h12345678, 16'd1);
    vectors++; if (o_paddr_valid !== 1'b1 || o_paddr !== 56'hABCDE678) begin
      miscompares++; $display("FAIL asid1_still got %b/%h want 1/abcde678", o_paddr_valid, o_paddr); end
    lookup(39'h12345678, 16'd3);
`ifdef CG_TLB_GLOBAL_EN
    vectors++; if (o_paddr_valid !== 1'b1 || o_paddr !== 56'h77777678) begin
      miscompares++; $display("FAIL global_hit got %b/%h want 1/77777678", o_paddr_valid, o_paddr); end
`else
    vectors++; if (o_miss_valid !== 1'b1) begin miscompares++; $display("FAIL asid3_miss got %b want 1", o_miss_valid); end
    respond(56'h0, 11'h0, 1'b1);
`endif
  endtask

  task automatic test_fault();
    lookup(39'h5000, 16'd1);
    vectors++; if (o_miss_valid !== 1'b1) begin miscompares++; $display("FAIL flt_miss got %b want 1", o_miss_valid); end
    respond(56'h99999000, 11'h0, 1'b1);
    vectors++; if (o_fault !== 1'b1 || o_paddr_valid !== 1'b0) begin
      miscompares++; $display("FAIL flt_strobe got %b/%b want 1/0", o_fault, o_paddr_valid); end
    @(posedge i_clk); #1;
    vectors++; if (o_fault !== 1'b0) begin miscompares++; $display("FAIL flt_pulse got %b want 0", o_fault); end
    lookup(39'h5000, 16'd1);
    vectors++; if (o_miss_valid !== 1'b1 || o_paddr_valid !== 1'b0) begin
      miscompares++; $display("FAIL flt_nofill got %b/%b want 1/0", o_miss_valid, o_paddr_valid); end
    respond(56'h0, 11'h0, 1'b1);
  endtask

  task automatic test_flush_asid();
    int busy;
    fill(39'h1000, 16'd1, 56'h11111000, 11'h0);
    fill(39'h1000, 16'd2, 56'h22222000, 11'h0);
    lookup(39'h1000, 16'd1);
    vectors++; if (o_paddr_valid !== 1'b1 || o_paddr !== 56'h11111000) begin
      miscompares++; $display("FAIL fa_pre got %b/%h want 1/11111000", o_paddr_valid, o_paddr); end
    do_flush(1'b1, 16'd1, 1'b0, 39'h0, busy);
    vectors++; if (busy != 8) begin miscompares++; $display("FAIL fa_busy got %0d want 8", busy); end
    lookup(39'h1000, 16'd1);
    vectors++; if (o_miss_valid !== 1'b1) begin miscompares++; $display("FAIL fa_a1_set1 got %b want 1", o_miss_valid); end
    respond(56'h0, 11'h0, 1'b1);
    lookup(39'h12345678, 16'd1);
    vectors++; if (o_miss_valid !== 1'b1) begin miscompares++; $display("FAIL fa_a1_set5 got %b want 1", o_miss_valid); end
    respond(56'h0, 11'h0, 1'b1);
    lookup(39'h1000, 16'd2);
    vectors++; if (o_paddr_valid !== 1'b1 || o_paddr !== 56'h22222000) begin
      miscompares++; $display("FAIL fa_a2_set1 got %b/%h want 1/22222000", o_paddr_valid, o_paddr); end
    lookup(39'h12345678, 16'd2);
    vectors++; if (o_paddr_valid !== 1'b1 || o_paddr !== 56'h77777678) begin
      miscompares++; $display("FAIL fa_a2_set5 got %b/%h want 1/77777678", o_paddr_valid, o_paddr); end
  endtask

  task automatic test_collision();
    i_flush_valid = 1'b1; i_flush_asid_en = 1'b0; i_flush_vaddr_en = 1'b1; i_flush_vaddr = 39'h3000;
    i_vaddr_valid = 1'b1; i_vaddr = 39'h12345678; i_asid = 16'd2;
    #1;
    vectors++; if (o_ready !== 1'b0 || o_flush_ready !== 1'b1) begin
      miscompares++; $display("FAIL col_ready got %b/%b want 0/1", o_ready, o_flush_ready); end
    @(posedge i_clk); #1;
    i_flush_valid = 1'b0;
    vectors++; if (o_paddr_valid !== 1'b0 || o_flush_ready !== 1'b0 || o_ready !== 1'b0) begin
      miscompares++; $display("FAIL col_flush got %b/%b/%b want 0/0/0", o_paddr_valid, o_flush_ready, o_ready); end
    @(posedge i_clk); #1;
    vectors++; if (o_ready !== 1'b1 || o_paddr_valid !== 1'b0) begin
      miscompares++; $display("FAIL col_idle got %b/%b want 1/0", o_ready, o_paddr_valid); end
    @(posedge i_clk); #1;
    i_vaddr_valid = 1'b0;
    vectors++; if (o_paddr_valid !== 1'b1 || o_paddr !== 56'h77777678) begin
      miscompares++; $display("FAIL col_lookup got %b/%h want 1/77777678", o_paddr_valid, o_paddr); end
  endtask

  task automatic test_reset_mid();
    lookup(39'h4000, 16'd1);
    vectors++; if (o_miss_valid !== 1'b1) begin miscompares++; $display("FAIL rm_req got %b want 1", o_miss_valid); end
    #2 i_rstn = 1'b0;
    #1;
    vectors++; if (o_miss_valid !== 1'b0) begin miscompares++; $display("FAIL rm_async_drop got %b want 0", o_miss_valid); end
    #2 i_rstn = 1'b1;
    @(posedge i_clk); #1;
    lookup(39'h12345678, 16'd2);
    vectors++; if (o_miss_valid !== 1'b1 || o_paddr_valid !== 1'b0) begin
      miscompares++; $display("FAIL rm_flushed got %b/%b want 1/0", o_miss_valid, o_paddr_valid); end
    i_miss_ready = 1'b1;
    @(posedge i_clk); #1;
    i_miss_ready = 1'b0;
    vectors++; if (o_ready !== 1'b0) begin miscompares++; $display("FAIL rm_wait got %b want 0", o_ready); end
    #2 i_rstn = 1'b0;
    #1;
    vectors++; if (o_ready !== 1'b1 || o_miss_valid !== 1'b0 || o_paddr_valid !== 1'b0) begin
      miscompares++; $display("FAIL rm_wait_abort got %b/%b/%b want 1/0/0", o_ready, o_miss_valid, o_paddr_valid); end
    #1 i_rstn = 1'b1;
    @(posedge i_clk); #1;
    i_ptw_valid = 1'b1; i_ptw_paddr = 56'h33333000;
    @(posedge i_clk); #1;
    i_ptw_valid = 1'b0;
    vectors++; if (o_paddr_valid !== 1'b0) begin miscompares++; $display("FAIL rm_late_ptw got %b want 0", o_paddr_valid); end
    lookup(39'h1000, 16'd2);
    vectors++; if (o_miss_valid !== 1'b1) begin miscompares++; $display("FAIL rm_all_miss got %b want 1", o_miss_valid); end
    respond(56'h0, 11'h0, 1'b1);
    lookup(39'h12345678, 16'd2);
    vectors++; if (o_miss_valid !== 1'b1) begin miscompares++; $display("FAIL rm_no_fill got %b want 1", o_miss_valid); end
    respond(56'h0, 11'h0, 1'b1);
  endtask

  initial begin
    #12;
    test_reset();
    #8 i_rstn = 1'b1;
    @(posedge i_clk); #1;
    test_miss_fill();
    test_replacement();
    test_flush_vaddr();
    test_asid();
    test_fault();
    test_flush_asid();
    test_collision();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
